// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate-extension mode codes and default widths.
//   EXT_* : 3-bit extension mode encodings (110/111 are reserved).
//   DATA_W, IMM_W, REG_TAG_W : default datapath, immediate and tag widths.
package cpu_pkg;

    typedef enum logic [2:0] {
        EXT_ZERO  = 3'b000,
        EXT_UPPER = 3'b001,
        EXT_SIGN  = 3'b010,
        EXT_ONES  = 3'b011,
        EXT_BR    = 3'b100,
        EXT_ZSH2  = 3'b101
    } ext_op_e;

    localparam int DATA_W    = 32;
    localparam int IMM_W     = 16;
    localparam int REG_TAG_W = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender.
//   in_imm  [IN_W]  : raw immediate field
//   in_op   [3]     : extension mode (ext_op_e encoding)
//   data    [OUT_W] : extended immediate (0 for reserved modes)
//   illegal [1]     : set when in_op is a reserved encoding
module imm_ext_core
    import cpu_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    output logic [OUT_W-1:0] data,
    output logic             illegal
);

    // Two spare bits are needed so the shift-by-2 modes never lose the
    // sign/upper extension region entirely.
    generate
        if (IN_W < 1 || IN_W > OUT_W - 2) begin : g_width_check
            $error("imm_ext_core: IN_W must be in 1..OUT_W-2");
        end
    endgenerate

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] oext;
    logic [OUT_W-1:0] upper;

    assign zext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
    assign sext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    assign oext  = {{(OUT_W-IN_W){1'b1}}, in_imm};
    assign upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (in_op)
            EXT_ZERO:  data = zext;
            EXT_UPPER: data = upper;
            EXT_SIGN:  data = sext;
            EXT_ONES:  data = oext;
            // Shifts happen at OUT_W bits; overflowed MSBs fall off.
            EXT_BR:    data = sext << 2;
            EXT_ZSH2:  data = zext << 2;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Elastic immediate-extension stage: extends the decode immediate, tags it
// and holds up to two results in a FIFO-ordered skid buffer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : upstream handshake (in_ready is registered)
//   in_imm, in_op, in_tag  : immediate, extension mode, sideband tag
//   flush                  : discard all buffered entries and any push this cycle
//   out_valid/out_ready    : downstream handshake on the head entry
//   out_data, out_tag, out_illegal : head entry contents (all 0 when empty)
module imm_ext_stage
    import cpu_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W,
    parameter int TAG_W = REG_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    logic [OUT_W-1:0] ext_data;
    logic             ext_illegal;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_op   (in_op),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [OUT_W-1:0] data_q    [2];
    logic [TAG_W-1:0] tag_q     [2];
    logic             illegal_q [2];
    logic [1:0]       count_q, count_d;
    logic             in_ready_q;

    logic push, pop, wr_idx;

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = (count_q != 2'd0) && out_ready && !flush;

    // New entry lands just behind whatever survives this cycle's pop.
    assign wr_idx = (count_q == 2'd1) && !pop;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            // Registered from next count so in_ready has no path from out_ready.
            in_ready_q <= (count_d != 2'd2);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q[gi]    <= '0;
                    tag_q[gi]     <= '0;
                    illegal_q[gi] <= 1'b0;
                end else if (push && (wr_idx == 1'(gi))) begin
                    data_q[gi]    <= ext_data;
                    tag_q[gi]     <= in_tag;
                    illegal_q[gi] <= ext_illegal;
                end else if (pop && gi == 0) begin
                    data_q[gi]    <= data_q[1];
                    tag_q[gi]     <= tag_q[1];
                    illegal_q[gi] <= illegal_q[1];
                end
            end
        end
    endgenerate

    assign in_ready    = in_ready_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = out_valid ? data_q[0]    : '0;
    assign out_tag     = out_valid ? tag_q[0]     : '0;
    assign out_illegal = out_valid ? illegal_q[0] : 1'b0;

endmodule
